id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter CW, default 16: control-bundle width; bit0 = regwrite, bit1 = isload, remaining bits are passed through.
REQ-003 SHALL have parameter BYPASS, default 1: when 1, same-cycle write-back to read forwarding is enabled.
REQ-004 SHALL have parameter SHAMT_EN, default 1: when 1, shift instructions replace op2 with the shift amount.
REQ-005 SHALL provide the following ports:
  clk  in  1  sole clock; all state updates on the rising edge
  rst  in  1  asynchronous active-low reset
  valid_d  in  1  decode instruction valid
  ready_d  out  1  decode can accept
  instr_d  in  32  instruction word
  pc_d  in  XLEN  instruction PC
  ctrl_d  in  CW  control bundle from the control unit
  regdest_d  in  1  1 selects rd = instr[15:11]; 0 selects instr[20:16]
  shift_d  in  1  instruction is an immediate shift
  flush  in  1  squash decode and E register
  wb_en  in  1  write-back enable
  wb_addr  in  5  write-back register
  wb_data  in  XLEN  write-back data
  valid_e  out  1  E register valid
  ready_e  in  1  execute can accept
  ctrl_e  out  CW  registered control bundle
  op1_e, op2_e, imm_e  out  XLEN  registered operands and immediate
  rs1_e, rs2_e, rd_e  out  5  registered register addresses
  pc_e  out  XLEN  registered PC
  hazard_stall  out  1  load-use stall indication

Function
REQ-006 SHALL contain 32 x XLEN registers; r0 SHALL read as 0 and writes to r0 SHALL be ignored.
REQ-007 SHALL write wb_data to reg[wb_addr] on a clk edge when wb_en=1 and wb_addr!=0.
REQ-008 SHALL read rs = instr_d[25:20..21] (bits 25:21) and rt = instr_d[20:16] combinationally.
REQ-009 SHALL, when BYPASS=1, return wb_data on a read port if wb_en=1, wb_addr equals that port's address and the address is nonzero; when BYPASS=0, the read SHALL return the old register value.
REQ-010 SHALL form imm as instr_d[15:0] sign-extended to XLEN.
REQ-011 SHALL, when SHAMT_EN=1 and shift_d=1, load op2_e with instr_d[10:6] zero-extended instead of reg[rt].
REQ-012 SHALL compute hazard = valid_e & ctrl_e[1] & (rd_e!=0) & valid_d & (rd_e==rs | rd_e==rt), combinationally.
REQ-013 SHALL drive hazard_stall = hazard & !flush.
REQ-014 SHALL drive ready_d = flush | (!hazard & (!valid_e | ready_e)).
REQ-015 SHALL update the E register only when advance = (!valid_e | ready_e), or when flush=1.
REQ-016 SHALL apply the following update priority: flush, then advance-with-hazard (insert a bubble), then advance-with-valid_d (load), then advance-without-valid_d (insert a bubble), then hold.
REQ-017 Load SHALL capture ctrl_d, the register-file reads, imm, rs, rt, pc_d and rd = regdest_d ? instr_d[15:11] : instr_d[20:16], and SHALL set valid_e=1.
REQ-018 Bubble and flush SHALL set valid_e=0 and zero every E output field.
REQ-019 Hold SHALL keep all E outputs unchanged, with no fetch acceptance unless flush=1.
REQ-020 Latency SHALL be one cycle from decode acceptance to valid_e.
REQ-021 A load-use dependency SHALL cost exactly one bubble cycle when ready_e=1 throughout.
REQ-022 Flush with valid_d=1 SHALL consume and discard the decode instruction; no register-file write SHALL be suppressed by flush.
REQ-023 A simultaneous write-back and load of the same register SHALL obey REQ-009 for the captured operand.

Reset
REQ-024 rst=0 SHALL, asynchronously: set valid_e=0, zero all E outputs, and clear all 32 registers to 0.
REQ-025 ready_d SHALL equal 1 while valid_e=0 following reset.
REQ-026 Reset asserted mid-stall SHALL drop the pending instruction, and the first edge after release SHALL behave as the first edge after power-up.

Verification
REQ-027 Write-back r5=0x1234 with valid_d=1 reading rs=5 in the same cycle -> BYPASS=1 gives op1_e=0x1234 next cycle; BYPASS=0 gives the old value 0.
REQ-028 lw r8 in E, then add using rt=8 in decode, with ready_e=1 -> hazard_stall=1 for 1 cycle, then a bubble (valid_e=0, ctrl_e=0), then the add loads.
REQ-029 ready_e=0 for 3 cycles with valid_e=1 -> E outputs stable, ready_d=0, and the next instruction loads on the cycle after ready_e returns to 1.
REQ-030 flush=1 while hazard=1 and ready_e=0 -> the next cycle has valid_e=0 and all E fields zero, and ready_d=1 during flush.
REQ-031 sll with shamt=7 and SHAMT_EN=1 -> op2_e=7; a write to r0 with 0xFFFF -> later read of r0=0; imm 0x8000 -> imm_e=0xFFFF8000 (XLEN=32).
REQ-032 rst pulsed low between edges mid-operation -> outputs zero immediately and register file reads 0 after release.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/execute boundary of a 5-stage pipeline.
// Holds the 32 x XLEN register file, reads rs/rt with optional write-back
// forwarding, forms the sign-extended immediate and the shift amount, and
// registers everything into the E register. A load in E whose destination
// is a source of the instruction in decode causes a one-cycle bubble.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   valid_d/ready_d     decode handshake
//   instr_d, pc_d       instruction word and PC in decode
//   ctrl_d              control bundle (bit0 regwrite, bit1 isload)
//   regdest_d           1: rd = instr[15:11], 0: rd = instr[20:16]
//   shift_d             immediate shift; op2 becomes instr[10:6]
//   flush               squash decode and the E register
//   wb_en/addr/data     register-file write-back port
//   valid_e/ready_e     execute handshake
//   ctrl_e, op1_e, op2_e, imm_e, rs1_e, rs2_e, rd_e, pc_e   E register
//   hazard_stall        load-use stall indication
module id_ex_stage #(
  parameter int XLEN     = 32,
  parameter int CW       = 16,
  parameter int BYPASS   = 1,
  parameter int SHAMT_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_d,
  output logic            ready_d,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [CW-1:0]   ctrl_d,
  input  logic            regdest_d,
  input  logic            shift_d,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            valid_e,
  input  logic            ready_e,
  output logic [CW-1:0]   ctrl_e,
  output logic [XLEN-1:0] op1_e,
  output logic [XLEN-1:0] op2_e,
  output logic [XLEN-1:0] imm_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic [XLEN-1:0] pc_e,
  output logic            hazard_stall
);

  typedef enum logic [1:0] {
    E_HOLD,
    E_LOAD,
    E_CLEAR
  } e_action_t;

  logic [XLEN-1:0] regs [32];

  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd_d;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic [XLEN-1:0] op2_d;
  logic [XLEN-1:0] imm_d;
  logic            hazard;
  logic            advance;
  e_action_t       action;

  // Opcode bits are decoded by the control unit, not here.
  logic unused_opcode;
  assign unused_opcode = ^instr_d[31:26];

  assign rs   = instr_d[25:21];
  assign rt   = instr_d[20:16];
  assign rd_d = regdest_d ? instr_d[15:11] : instr_d[20:16];

  // Register file; r0 is never written so it always reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_val = '0;
    if (rs != 5'd0) begin
      if ((BYPASS != 0) && wb_en && (wb_addr == rs)) rs_val = wb_data;
      else                                            rs_val = regs[rs];
    end
  end

  always_comb begin
    rt_val = '0;
    if (rt != 5'd0) begin
      if ((BYPASS != 0) && wb_en && (wb_addr == rt)) rt_val = wb_data;
      else                                            rt_val = regs[rt];
    end
  end

  assign imm_d = {{(XLEN-16){instr_d[15]}}, instr_d[15:0]};

  always_comb begin
    op2_d = rt_val;
    if ((SHAMT_EN != 0) && shift_d) op2_d = {{(XLEN-5){1'b0}}, instr_d[10:6]};
  end

  // Load in E feeding either source of the decode instruction.
  assign hazard = valid_e & ctrl_e[1] & (rd_e != 5'd0) & valid_d &
                  ((rd_e == rs) | (rd_e == rt));

  assign advance      = ~valid_e | ready_e;
  assign hazard_stall = hazard & ~flush;
  assign ready_d      = flush | (~hazard & advance);

  // Flush wins over everything; a hazard or an empty decode slot on advance
  // both collapse into the same bubble.
  always_comb begin
    action = E_HOLD;
    if (flush)                       action = E_CLEAR;
    else if (advance && hazard)      action = E_CLEAR;
    else if (advance && valid_d)     action = E_LOAD;
    else if (advance)                action = E_CLEAR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_e <= 1'b0;
      ctrl_e  <= '0;
      op1_e   <= '0;
      op2_e   <= '0;
      imm_e   <= '0;
      rs1_e   <= '0;
      rs2_e   <= '0;
      rd_e    <= '0;
      pc_e    <= '0;
    end else begin
      case (action)
        E_LOAD: begin
          valid_e <= 1'b1;
          ctrl_e  <= ctrl_d;
          op1_e   <= rs_val;
          op2_e   <= op2_d;
          imm_e   <= imm_d;
          rs1_e   <= rs;
          rs2_e   <= rt;
          rd_e    <= rd_d;
          pc_e    <= pc_d;
        end
        E_CLEAR: begin
          valid_e <= 1'b0;
          ctrl_e  <= '0;
          op1_e   <= '0;
          op2_e   <= '0;
          imm_e   <= '0;
          rs1_e   <= '0;
          rs2_e   <= '0;
          rd_e    <= '0;
          pc_e    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [15:0] ctrl_d;
  logic        regdest_d;
  logic        shift_d;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ready_e;

  logic        ready_d, valid_e, hazard_stall;
  logic [15:0] ctrl_e;
  logic [31:0] op1_e, op2_e, imm_e, pc_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;

  logic        nb_ready_d, nb_valid_e, nb_hazard_stall;
  logic [15:0] nb_ctrl_e;
  logic [31:0] nb_op1_e, nb_op2_e, nb_imm_e, nb_pc_e;
  logic [4:0]  nb_rs1_e, nb_rs2_e, nb_rd_e;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .ready_d(ready_d),
    .instr_d(instr_d), .pc_d(pc_d), .ctrl_d(ctrl_d), .regdest_d(regdest_d),
    .shift_d(shift_d), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .valid_e(valid_e), .ready_e(ready_e), .ctrl_e(ctrl_e),
    .op1_e(op1_e), .op2_e(op2_e), .imm_e(imm_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .pc_e(pc_e), .hazard_stall(hazard_stall)
  );

  id_ex_stage #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .valid_d(valid_d), .ready_d(nb_ready_d),
    .instr_d(instr_d), .pc_d(pc_d), .ctrl_d(ctrl_d), .regdest_d(regdest_d),
    .shift_d(shift_d), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .valid_e(nb_valid_e), .ready_e(ready_e), .ctrl_e(nb_ctrl_e),
    .op1_e(nb_op1_e), .op2_e(nb_op2_e), .imm_e(nb_imm_e), .rs1_e(nb_rs1_e),
    .rs2_e(nb_rs2_e), .rd_e(nb_rd_e), .pc_e(nb_pc_e), .hazard_stall(nb_hazard_stall)
  );

  // Reference model: architectural register contents plus the E slot.
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [15:0] m_ctrl;
  logic [31:0] m_op1, m_op2, m_imm, m_pc, m_op1nb, m_op2nb;
  logic [4:0]  m_rs, m_rt, m_rd;

  function automatic logic [31:0] mk(input logic [4:0] s, input logic [4:0] t,
                                     input logic [15:0] low);
    logic [31:0] w;
    w = $urandom;
    w[25:21] = s;
    w[20:16] = t;
    w[15:0]  = low;
    return w;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic byp);
    if (a == 5'd0) return 32'd0;
    if (byp && wb_en && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic logic m_hazard();
    return m_valid && m_ctrl[1] && m_rd != 5'd0 && valid_d &&
           (m_rd == instr_d[25:21] || m_rd == instr_d[20:16]);
  endfunction

  function automatic logic m_ready_d();
    return flush || (!m_hazard() && (!m_valid || ready_e));
  endfunction

  task automatic m_clear_e();
    m_valid = 0; m_ctrl = '0; m_op1 = '0; m_op2 = '0; m_imm = '0; m_pc = '0;
    m_op1nb = '0; m_op2nb = '0; m_rs = '0; m_rt = '0; m_rd = '0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_clear_e();
  endtask

  task automatic idle();
    valid_d = 0; instr_d = '0; pc_d = '0; ctrl_d = '0; regdest_d = 0;
    shift_d = 0; flush = 0; wb_en = 0; wb_addr = '0; wb_data = '0; ready_e = 1;
  endtask

  // Advance one clock; the model decides from the inputs present before the edge.
  task automatic tick();
    logic adv, clr;
    logic [31:0] o1, o2, o1n, o2n, shamt;
    adv   = !m_valid || ready_e;
    clr   = flush || (adv && (m_hazard() || !valid_d));
    shamt = {27'd0, instr_d[10:6]};
    o1  = m_read(instr_d[25:21], 1'b1);
    o2  = shift_d ? shamt : m_read(instr_d[20:16], 1'b1);
    o1n = m_read(instr_d[25:21], 1'b0);
    o2n = shift_d ? shamt : m_read(instr_d[20:16], 1'b0);
    @(posedge clk);
    #1;
    if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
    if (clr) m_clear_e();
    else if (adv) begin
      m_valid = 1; m_ctrl = ctrl_d; m_op1 = o1; m_op2 = o2; m_op1nb = o1n; m_op2nb = o2n;
      m_imm = {{16{instr_d[15]}}, instr_d[15:0]}; m_pc = pc_d;
      m_rs = instr_d[25:21]; m_rt = instr_d[20:16];
      m_rd = regdest_d ? instr_d[15:11] : instr_d[20:16];
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if ({valid_e, ctrl_e, op1_e, op2_e, imm_e, rs1_e, rs2_e, rd_e, pc_e} !== 160'd0) begin
      n_mis++;
      $display("FAIL reset_e_fields: got valid=%0b ctrl=%h op1=%h pc=%h, want all zero",
               valid_e, ctrl_e, op1_e, pc_e);
    end
    n_vec++;
    if (ready_d !== 1'b1) begin
      n_mis++; $display("FAIL reset_ready_d: got %b want 1", ready_d);
    end
    valid_d = 1; instr_d = mk(5'd31, 5'd30, 16'h0000); ctrl_d = 16'h0001;
    tick();
    n_vec++;
    if (valid_e !== 1'b1 || op1_e !== 32'd0 || op2_e !== 32'd0) begin
      n_mis++;
      $display("FAIL reset_regfile_zero: got valid=%b op1=%h op2=%h want 1/0/0",
               valid_e, op1_e, op2_e);
    end
    idle(); tick();
  endtask

  task automatic test_bypass();
    valid_d = 1; instr_d = mk(5'd5, 5'd0, 16'h0000); ctrl_d = 16'h0001;
    wb_en = 1; wb_addr = 5'd5; wb_data = 32'h1234;
    tick();
    n_vec++;
    if (op1_e !== 32'h1234) begin
      n_mis++; $display("FAIL bypass_on_op1: got %h want 00001234", op1_e);
    end
    n_vec++;
    if (nb_op1_e !== 32'h0) begin
      n_mis++; $display("FAIL bypass_off_op1: got %h want 00000000", nb_op1_e);
    end
    idle(); tick();
  endtask

  task automatic test_load_use();
    valid_d = 1; instr_d = mk(5'd1, 5'd8, 16'h0004); ctrl_d = 16'h0003; regdest_d = 0;
    pc_d = 32'h100;
    tick();
    instr_d = mk(5'd2, 5'd8, {5'd9, 11'd0}); ctrl_d = 16'h0001; regdest_d = 1;
    pc_d = 32'h104;
    #1;
    n_vec++;
    if (hazard_stall !== 1'b1 || ready_d !== 1'b0) begin
      n_mis++; $display("FAIL load_use_stall: got stall=%b ready_d=%b want 1/0",
                        hazard_stall, ready_d);
    end
    tick();
    n_vec++;
    if (valid_e !== 1'b0 || ctrl_e !== 16'h0) begin
      n_mis++; $display("FAIL load_use_bubble: got valid=%b ctrl=%h want 0/0000", valid_e, ctrl_e);
    end
    n_vec++;
    if (hazard_stall !== 1'b0 || ready_d !== 1'b1) begin
      n_mis++; $display("FAIL load_use_release: got stall=%b ready_d=%b want 0/1",
                        hazard_stall, ready_d);
    end
    tick();
    n_vec++;
    if (valid_e !== 1'b1 || rd_e !== 5'd9 || rs2_e !== 5'd8 || pc_e !== 32'h104) begin
      n_mis++; $display("FAIL load_use_add: got valid=%b rd=%0d rs2=%0d pc=%h want 1/9/8/104",
                        valid_e, rd_e, rs2_e, pc_e);
    end
    idle(); tick();
  endtask

  task automatic test_stall();
    logic [159:0] held;
    valid_d = 1; instr_d = mk(5'd3, 5'd4, 16'h1234); ctrl_d = 16'h00F1; pc_d = 32'h200;
    tick();
    held = {valid_e, ctrl_e, op1_e, op2_e, imm_e, rs1_e, rs2_e, rd_e, pc_e};
    instr_d = mk(5'd6, 5'd7, 16'h0042); pc_d = 32'h204; ready_e = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (ready_d !== 1'b0) begin
        n_mis++; $display("FAIL stall_ready_d: cycle %0d got %b want 0", c, ready_d);
      end
      tick();
      n_vec++;
      if ({valid_e, ctrl_e, op1_e, op2_e, imm_e, rs1_e, rs2_e, rd_e, pc_e} !== held ||
          pc_e !== 32'h200) begin
        n_mis++; $display("FAIL stall_hold: cycle %0d got pc=%h valid=%b want pc=00000200 unchanged",
                          c, pc_e, valid_e);
      end
    end
    ready_e = 1;
    #1;
    n_vec++;
    if (ready_d !== 1'b1) begin
      n_mis++; $display("FAIL stall_resume_ready: got %b want 1", ready_d);
    end
    tick();
    n_vec++;
    if (pc_e !== 32'h204 || imm_e !== 32'h42 || valid_e !== 1'b1) begin
      n_mis++; $display("FAIL stall_resume_load: got pc=%h imm=%h want 00000204/00000042",
                        pc_e, imm_e);
    end
    idle(); tick();
  endtask

  task automatic test_flush();
    valid_d = 1; instr_d = mk(5'd1, 5'd8, 16'h0000); ctrl_d = 16'h0003; pc_d = 32'h300;
    tick();
    ready_e = 0; instr_d = mk(5'd8, 5'd2, 16'h0000); ctrl_d = 16'h0001; flush = 1;
    wb_en = 1; wb_addr = 5'd3; wb_data = 32'hCAFE0003;
    #1;
    n_vec++;
    if (ready_d !== 1'b1 || hazard_stall !== 1'b0) begin
      n_mis++; $display("FAIL flush_ready: got ready_d=%b stall=%b want 1/0", ready_d, hazard_stall);
    end
    tick();
    n_vec++;
    if ({valid_e, ctrl_e, op1_e, op2_e, imm_e, rs1_e, rs2_e, rd_e, pc_e} !== 160'd0) begin
      n_mis++; $display("FAIL flush_clear: got valid=%b ctrl=%h rd=%0d pc=%h want all zero",
                        valid_e, ctrl_e, rd_e, pc_e);
    end
    idle();
    valid_d = 1; instr_d = mk(5'd3, 5'd0, 16'h0000); ctrl_d = 16'h0001;
    tick();
    n_vec++;
    if (op1_e !== 32'hCAFE0003) begin
      n_mis++; $display("FAIL flush_wb_kept: got %h want cafe0003", op1_e);
    end
    idle(); tick();
  endtask

  task automatic test_shift_imm_r0();
    wb_en = 1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    tick();
    idle();
    valid_d = 1; shift_d = 1; instr_d = mk(5'd0, 5'd9, {5'd10, 5'd7, 6'd0}); ctrl_d = 16'h0001;
    tick();
    n_vec++;
    if (op2_e !== 32'd7 || op1_e !== 32'd0) begin
      n_mis++; $display("FAIL shamt_r0: got op2=%h op1=%h want 00000007/00000000", op2_e, op1_e);
    end
    shift_d = 0; instr_d = mk(5'd0, 5'd0, 16'h8000);
    tick();
    n_vec++;
    if (imm_e !== 32'hFFFF8000 || op2_e !== 32'd0) begin
      n_mis++; $display("FAIL imm_sext: got imm=%h op2=%h want ffff8000/00000000", imm_e, op2_e);
    end
    idle(); tick();
  endtask

  task automatic test_random();
    logic [159:0] exp_b, act_b;
    for (int n = 0; n < 400; n++) begin
      valid_d   = ($urandom_range(0, 9) < 8);
      instr_d   = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
      instr_d[15:11] = 5'($urandom_range(0, 7));
      pc_d      = $urandom;
      ctrl_d    = 16'($urandom);
      regdest_d = 1'($urandom);
      shift_d   = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      wb_en     = 1'($urandom);
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      ready_e   = ($urandom_range(0, 9) < 7);
      #1;
      n_vec++;
      if (ready_d !== m_ready_d() || hazard_stall !== (m_hazard() && !flush)) begin
        n_mis++; $display("FAIL rand_comb: step %0d got ready_d=%b stall=%b want %b/%b",
                          n, ready_d, hazard_stall, m_ready_d(), m_hazard() && !flush);
      end
      tick();
      exp_b = {m_valid, m_ctrl, m_op1, m_op2, m_imm, m_rs, m_rt, m_rd, m_pc};
      act_b = {valid_e, ctrl_e, op1_e, op2_e, imm_e, rs1_e, rs2_e, rd_e, pc_e};
      n_vec++;
      if (act_b !== exp_b) begin
        n_mis++; $display("FAIL rand_e: step %0d got %h want %h", n, act_b, exp_b);
      end
      n_vec++;
      if (nb_op1_e !== m_op1nb || nb_op2_e !== m_op2nb) begin
        n_mis++; $display("FAIL rand_nobypass: step %0d got %h/%h want %h/%h",
                          n, nb_op1_e, nb_op2_e, m_op1nb, m_op2nb);
      end
    end
    idle(); tick();
  endtask

  task automatic test_async_reset();
    wb_en = 1; wb_addr = 5'd4; wb_data = 32'hDEAD0004;
    tick();
    idle();
    valid_d = 1; instr_d = mk(5'd4, 5'd4, 16'h1111); ctrl_d = 16'h0003; ready_e = 0;
    tick();
    tick();
    #2;
    rst = 0;
    #1;
    n_vec++;
    if ({valid_e, ctrl_e, op1_e, op2_e, imm_e, rs1_e, rs2_e, rd_e, pc_e} !== 160'd0 ||
        ready_d !== 1'b1) begin
      n_mis++; $display("FAIL async_reset_now: got valid=%b op1=%h ready_d=%b want 0/0/1",
                        valid_e, op1_e, ready_d);
    end
    idle();
    #1;
    rst = 1;
    m_reset();
    valid_d = 1; instr_d = mk(5'd4, 5'd4, 16'h0000); ctrl_d = 16'h0001;
    tick();
    n_vec++;
    if (valid_e !== 1'b1 || op1_e !== 32'd0 || op2_e !== 32'd0) begin
      n_mis++; $display("FAIL async_reset_regs: got valid=%b op1=%h op2=%h want 1/0/0",
                        valid_e, op1_e, op2_e);
    end
    idle(); tick();
  endtask

  initial begin
    idle();
    m_reset();
    rst = 0;
    #12;
    rst = 1;
    test_reset();
    test_bypass();
    test_load_use();
    test_stall();
    test_flush();
    test_shift_imm_r0();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
